// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit: funct3 access-width codes and
// the transaction FSM state encoding.
// -----------------------------------------------------------------------------
package lsu_pkg;

  // funct3 width codes shared by loads and stores (BU/HU are load-only)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } lsu_state_e;

endpackage : lsu_pkg

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational alignment helper.
//   Request side : from the raw decoded op and the byte lane of the effective
//                  address, produce lane-replicated store data, byte strobes,
//                  and the misaligned / illegal classification.
//   Response side: from a stored width code and lane, extract the byte/half
//                  from a 32-bit read word and sign- or zero-extend it.
// Ports:
//   is_load, is_store, funct3, lane, store_data -> wdata, wstrb,
//                                                  misaligned, illegal
//   ld_funct3, ld_lane, rdata                   -> load_data
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned,
  output logic        illegal,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_lane,
  input  logic [31:0] rdata,
  output logic [31:0] load_data
);

  logic        ld_code_ok;
  logic        st_code_ok;
  logic signed [7:0]  rd_byte;
  logic signed [15:0] rd_half;

  // Store lanes: the memory picks the lane via strobes, so the data is simply
  // replicated across all lanes.
  always_comb begin
    wdata = '0;
    wstrb = '0;
    if (is_store) begin
      case (funct3)
        F3_B: begin
          wdata = {4{store_data[7:0]}};
          wstrb = 4'b0001 << lane;
        end
        F3_H: begin
          wdata = {2{store_data[15:0]}};
          wstrb = 4'b0011 << lane;
        end
        F3_W: begin
          wdata = store_data;
          wstrb = 4'b1111;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ld_code_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                 (funct3 == F3_BU) || (funct3 == F3_HU);
    st_code_ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    illegal    = (is_load && is_store) ||
                 (is_load && !ld_code_ok) ||
                 (is_store && !st_code_ok);
    misaligned = (is_load || is_store) &&
                 ((((funct3 == F3_H) || (funct3 == F3_HU)) && lane[0]) ||
                  ((funct3 == F3_W) && (lane != 2'b00)));
  end

  // Load extraction; halves are only ever at lane 0 or 2 once aligned.
  always_comb begin
    rd_byte   = rdata[{ld_lane, 3'b000} +: 8];
    rd_half   = ld_lane[1] ? rdata[31:16] : rdata[15:0];
    load_data = '0;
    case (ld_funct3)
      F3_B:    load_data = 32'(rd_byte);
      F3_H:    load_data = 32'(rd_half);
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'd0, rd_byte};
      F3_HU:   load_data = {16'd0, rd_half};
      default: load_data = '0;
    endcase
  end

endmodule : lsu_align

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Executes one decoded load or store as a single-beat req/ready transaction on
// the data-memory port and returns extended load data for writeback.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   start, is_load, is_store,      decoded op, sampled only when idle
//   funct3, base, offset,
//   store_data
//   busy, done, wb_en, load_data   core handshake / writeback
//   misaligned, illegal            one-cycle error pulses alongside done
//   mem_req, mem_we, mem_addr,     registered data-memory request
//   mem_wdata, mem_wstrb
//   mem_ready, mem_rdata           memory completion and read data
// -----------------------------------------------------------------------------
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       base,
  input  logic [31:0]       offset,
  input  logic [31:0]       store_data,
  output logic              busy,
  output logic              done,
  output logic              wb_en,
  output logic [31:0]       load_data,
  output logic              misaligned,
  output logic              illegal,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        lane_q, lane_d;
  logic              is_ld_q, is_ld_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              mis_q, mis_d;
  logic              ill_q, ill_d;

  logic [31:0] ea;
  logic        accept;
  logic [31:0] al_wdata;
  logic [3:0]  al_wstrb;
  logic        al_mis;
  logic        al_ill;
  logic [31:0] al_load;

  assign ea     = base + offset;
  assign accept = (state_q == ST_IDLE) && start && (is_load || is_store);

  // Request side uses the live decode; response side uses the width/lane
  // captured at accept, since the decode inputs may change while waiting.
  lsu_align u_align (
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .lane       (ea[1:0]),
    .store_data (store_data),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .misaligned (al_mis),
    .illegal    (al_ill),
    .ld_funct3  (f3_q),
    .ld_lane    (lane_q),
    .rdata      (mem_rdata),
    .load_data  (al_load)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    f3_d      = f3_q;
    lane_d    = lane_q;
    is_ld_d   = is_ld_q;
    ld_data_d = ld_data_q;
    mis_d     = mis_q;
    ill_d     = ill_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          mis_d = al_mis;
          ill_d = al_ill;
          if (al_mis || al_ill) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_REQ;
            addr_d  = ADDR_W'({ea[31:2], 2'b00});
            we_d    = is_store;
            wdata_d = is_store ? al_wdata : '0;
            wstrb_d = al_wstrb;
            f3_d    = funct3;
            lane_d  = ea[1:0];
            is_ld_d = is_load;
          end
        end
      end
      ST_REQ: begin
        if (mem_ready) begin
          state_d = ST_RESP;
          if (is_ld_q) ld_data_d = al_load;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Every visible output resets to zero, so the datapath registers reset too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      f3_q      <= '0;
      lane_q    <= '0;
      is_ld_q   <= 1'b0;
      ld_data_q <= '0;
      mis_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      f3_q      <= f3_d;
      lane_q    <= lane_d;
      is_ld_q   <= is_ld_d;
      ld_data_q <= ld_data_d;
      mis_q     <= mis_d;
      ill_q     <= ill_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign wb_en      = (state_q == ST_RESP) && is_ld_q;
  assign load_data  = ld_data_q;
  // Illegal wins when both classifications apply.
  assign illegal    = (state_q == ST_ERR) && ill_q;
  assign misaligned = (state_q == ST_ERR) && mis_q && !ill_q;
  assign mem_req    = (state_q == ST_REQ);
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;

endmodule : load_store_unit

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [31:0] offset;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic        wb_en;
  logic [31:0] load_data;
  logic        misaligned;
  logic        illegal;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int checks   = 0;
  int failures = 0;
  int ready_delay = 0;
  int req_cyc = 0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .base       (base),
    .offset     (offset),
    .store_data (store_data),
    .busy       (busy),
    .done       (done),
    .wb_en      (wb_en),
    .load_data  (load_data),
    .misaligned (misaligned),
    .illegal    (illegal),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: ready after ready_delay cycles of mem_req being high.
  always @(posedge clk) begin
    if (mem_req) req_cyc <= req_cyc + 1;
    else         req_cyc <= 0;
  end
  assign mem_ready = mem_req && (req_cyc >= ready_delay);

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [31:0] off;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic [1:0]  err;     // 0 none, 1 misaligned, 2 illegal
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_strb;
    logic [31:0] e_ld;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic ld, input logic st,
                              input logic [2:0] f3, input logic [31:0] b,
                              input logic [31:0] o, input logic [31:0] sd,
                              input logic [31:0] rd, input logic [1:0] err,
                              input logic [31:0] ea, input logic [31:0] wd,
                              input logic [3:0] sb, input logic [31:0] ldv);
    vec_t v;
    v.name = n; v.ld = ld; v.st = st; v.f3 = f3; v.base = b; v.off = o;
    v.sdata = sd; v.rdata = rd; v.err = err; v.e_addr = ea; v.e_wdata = wd;
    v.e_strb = sb; v.e_ld = ldv;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    is_load = v.ld; is_store = v.st; funct3 = v.f3; base = v.base;
    offset = v.off; store_data = v.sdata; mem_rdata = v.rdata; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({v.name, ".busy1"}, 32'(busy), 32'd1);
    if (v.err != 2'd0) begin
      chk({v.name, ".done_err"}, 32'(done), 32'd1);
      chk({v.name, ".misaligned"}, 32'(misaligned), 32'(v.err == 2'd1));
      chk({v.name, ".illegal"}, 32'(illegal), 32'(v.err == 2'd2));
      chk({v.name, ".req_err"}, 32'(mem_req), 32'd0);
      chk({v.name, ".wb_err"}, 32'(wb_en), 32'd0);
    end else begin
      chk({v.name, ".req"}, 32'(mem_req), 32'd1);
      chk({v.name, ".done_early"}, 32'(done), 32'd0);
      chk({v.name, ".addr"}, mem_addr, v.e_addr);
      chk({v.name, ".we"}, 32'(mem_we), 32'(v.st));
      chk({v.name, ".wstrb"}, 32'(mem_wstrb), 32'(v.e_strb));
      if (v.st) chk({v.name, ".wdata"}, mem_wdata, v.e_wdata);
      @(negedge clk);
      chk({v.name, ".done"}, 32'(done), 32'd1);
      chk({v.name, ".wb_en"}, 32'(wb_en), 32'(v.ld));
      chk({v.name, ".req_off"}, 32'(mem_req), 32'd0);
      if (v.ld) chk({v.name, ".load_data"}, load_data, v.e_ld);
    end
    @(negedge clk);
    chk({v.name, ".idle_busy"}, 32'(busy), 32'd0);
    chk({v.name, ".idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk("lw_basic", 1, 0, 3'b010, 32'h100, 32'h4, 0, 32'hDEADBEEF, 0, 32'h104, 0, 4'b0000, 32'hDEADBEEF);
    vecs[1]  = mk("lb_l3",    1, 0, 3'b000, 32'h3, 0, 0, 32'h80FF7F01, 0, 32'h0, 0, 4'b0000, 32'hFFFFFF80);
    vecs[2]  = mk("lbu_l3",   1, 0, 3'b100, 32'h3, 0, 0, 32'h80FF7F01, 0, 32'h0, 0, 4'b0000, 32'h00000080);
    vecs[3]  = mk("lb_l1",    1, 0, 3'b000, 32'h1, 0, 0, 32'h80FF7F01, 0, 32'h0, 0, 4'b0000, 32'h0000007F);
    vecs[4]  = mk("lh_l2",    1, 0, 3'b001, 32'h2, 0, 0, 32'h80FF7F01, 0, 32'h0, 0, 4'b0000, 32'hFFFF80FF);
    vecs[5]  = mk("lhu_l2",   1, 0, 3'b101, 32'h2, 0, 0, 32'h80FF7F01, 0, 32'h0, 0, 4'b0000, 32'h000080FF);
    vecs[6]  = mk("sb_203",   0, 1, 3'b000, 32'h200, 32'h3, 32'h000000AB, 0, 0, 32'h200, 32'hABABABAB, 4'b1000, 0);
    vecs[7]  = mk("sh_202",   0, 1, 3'b001, 32'h200, 32'h2, 32'h00001234, 0, 0, 32'h200, 32'h12341234, 4'b1100, 0);
    vecs[8]  = mk("sw_300",   0, 1, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 0, 0, 32'h300, 32'hCAFEF00D, 4'b1111, 0);
    vecs[9]  = mk("lw_mis",   1, 0, 3'b010, 32'h100, 32'h2, 0, 0, 1, 0, 0, 0, 0);
    vecs[10] = mk("sh_mis",   0, 1, 3'b001, 32'h0, 32'h1, 0, 0, 1, 0, 0, 0, 0);
    vecs[11] = mk("st_f3_100",0, 1, 3'b100, 32'h40, 32'h0, 0, 0, 2, 0, 0, 0, 0);
    vecs[12] = mk("lw_wrap",  1, 0, 3'b010, 32'hFFFFFFFC, 32'h8, 0, 32'h11223344, 0, 32'h4, 0, 4'b0000, 32'h11223344);
    vecs[13] = mk("ld_and_st",1, 1, 3'b010, 32'h40, 32'h0, 0, 0, 2, 0, 0, 0, 0);
    vecs[14] = mk("ill_prio", 1, 0, 3'b011, 32'h1, 32'h0, 0, 0, 2, 0, 0, 0, 0);
    vecs[15] = mk("lw_negoff",1, 0, 3'b010, 32'h108, 32'hFFFFFFFC, 0, 32'h0BADF00D, 0, 32'h104, 0, 4'b0000, 32'h0BADF00D);

    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = '0;
    base = '0; offset = '0; store_data = '0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.wb_en", 32'(wb_en), 0);
    chk("rst.load_data", load_data, 0);
    chk("rst.misaligned", 32'(misaligned), 0);
    chk("rst.illegal", 32'(illegal), 0);
    chk("rst.mem_req", 32'(mem_req), 0);
    chk("rst.mem_we", 32'(mem_we), 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.mem_wstrb", 32'(mem_wstrb), 0);
    rst = 1'b0;

    // start with neither flag is ignored
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("noop.busy", 32'(busy), 0);
    chk("noop.req", 32'(mem_req), 0);

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // Delayed ready with an ignored second start while waiting
    begin
      int lat;
      ready_delay = 5;
      lat = 0;
      @(negedge clk);
      is_load = 1; is_store = 0; funct3 = 3'b010; base = 32'h40; offset = 0;
      mem_rdata = 32'h55AA1234; start = 1;
      @(negedge clk);
      start = 0;
      for (int c = 1; c <= 20; c++) begin
        if (c == 1) begin
          start = 1; is_load = 0; is_store = 1; base = 32'h500; store_data = 32'hFFFFFFFF;
        end
        if (c == 3) start = 0;
        if (done) begin
          lat = c;
          break;
        end
        if (c <= 6) begin
          chk("wait.req", 32'(mem_req), 1);
          chk("wait.addr", mem_addr, 32'h40);
          chk("wait.we", 32'(mem_we), 0);
        end
        @(negedge clk);
      end
      chk("wait.latency", 32'(lat), 7);
      chk("wait.wb_en", 32'(wb_en), 1);
      chk("wait.load_data", load_data, 32'h55AA1234);
      @(negedge clk);
      chk("wait.after_busy", 32'(busy), 0);
      chk("wait.after_req", 32'(mem_req), 0);
      ready_delay = 0;
      is_store = 0;
    end

    // Reset during REQ abandons the transaction
    begin
      int done_seen;
      done_seen = 0;
      ready_delay = 100;
      @(negedge clk);
      is_load = 0; is_store = 1; funct3 = 3'b010; base = 32'h600; offset = 0;
      store_data = 32'h12345678; start = 1;
      @(negedge clk);
      start = 0;
      chk("rstreq.req_before", 32'(mem_req), 1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      chk("rstreq.req", 32'(mem_req), 0);
      chk("rstreq.busy", 32'(busy), 0);
      chk("rstreq.addr", mem_addr, 0);
      for (int c = 0; c < 5; c++) begin
        if (done) done_seen++;
        @(negedge clk);
      end
      chk("rstreq.no_done", 32'(done_seen), 0);
      ready_delay = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_load_store_unit

// File: doc/load_store_unit.md
# load_store_unit

Memory-side counterpart to the instruction decoder's load/store outputs. Takes a decoded load or store (funct3 width code, base register value, immediate offset, store data), computes the effective address, and runs a single-beat request/ready transaction on the data-memory port. It then returns sign- or zero-extended load data for writeback. The core stalls on `busy` while a transaction is in flight.

## Interface
Parameters:
- `ADDR_W`, 32, effective/memory address width (data width fixed at 32)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  launch request; sampled only in IDLE
- `is_load`  in  1  decoded load
- `is_store`  in  1  decoded store
- `funct3`  in  3  width code (load_type/store_type encoding)
- `base`  in  32  rs1 value
- `offset`  in  32  sign-extended immediate
- `store_data`  in  32  rs2 value
- `busy`  out  1  high from accept until the cycle after completion
- `done`  out  1  one-cycle completion pulse
- `wb_en`  out  1  high with `done` for successful loads only
- `load_data`  out  32  extended load result, valid when `wb_en`
- `misaligned`  out  1  one-cycle error pulse
- `illegal`  out  1  one-cycle error pulse
- `mem_req`  out  1  memory request
- `mem_we`  out  1  1 = write
- `mem_addr`  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- `mem_wdata`  out  32  lane-shifted store data
- `mem_wstrb`  out  4  byte enables (0 on reads)
- `mem_ready`  in  1  memory accepts/completes the beat
- `mem_rdata`  in  32  read data, valid with `mem_ready` on reads

## Operation
- Effective address `ea = base + offset`, modulo 2^32, latched at accept. Lane = `ea[1:0]`.
- Funct3 codes: 000 B, 001 H, 010 W, 100 BU, 101 HU. BU and HU are legal for loads only. Any other code, or `is_load && is_store`, is illegal.
- Misaligned: H/HU with `ea[0]=1`; W with `ea[1:0]!=0`. No memory access is issued.
- States:
  - IDLE: `start && (is_load || is_store)` → REQ if legal and aligned, else ERR. `start` with neither flag set is ignored.
  - REQ: `mem_req=1`, with address, write enable, data and strobes held stable. `mem_ready` → RESP.
  - RESP: `done=1`. For loads, `wb_en=1` and `load_data` is valid. → IDLE.
  - ERR: `done=1` plus `misaligned` or `illegal` (illegal takes priority). → IDLE.
- Stores:
  - `mem_wdata` = B: byte replicated ×4; H: half replicated ×2; W: as-is.
  - `mem_wstrb` = B: `4'b0001<<lane`; H: `4'b0011<<lane`; W: `4'b1111`.
- Loads: select the byte or half at `lane` from `mem_rdata` (captured on `mem_ready`). B/H sign-extend from bit 7/15. BU/HU zero-extend.
- `start` while `busy` is ignored.
- Reset values: state IDLE; every output 0, including `load_data` and `mem_addr`.
- Reset mid-REQ: `mem_req` drops at that edge; the transaction is abandoned and no `done` is issued.

## Timing
- Accept edge T0 → `mem_req` high from T0+1. `mem_ready` sampled at edge T0+1+k → `done` high in cycle T0+2+k.
- Zero-wait memory gives 2-cycle latency. `busy` is high T0+1 through the `done` cycle.
- `mem_req` stays high until `mem_ready`, with no timeout. Its outputs are registered and do not change while waiting.
- Error path: `done` + error pulse in T0+1; `mem_req` never asserts.
- A new `start` is accepted at the earliest in the cycle after `done`. Back-to-back throughput: one op per 3 cycles with zero-wait memory.

## Structure
- Shared package `lsu_pkg`: funct3 width constants, FSM state enum (IDLE/REQ/RESP/ERR).
- Sub-module `lsu_align` (combinational): store lane shift and strobe generation, load extract and extension, misaligned and illegal detection. It is shared by the FSM and reusable for a future fetch path.

## Test plan
- Zero-wait memory, LW `base=0x100`, `offset=4`, `mem_rdata=0xDEADBEEF` → `mem_addr=0x104`, `load_data=0xDEADBEEF`, `done` at T0+2.
- Per-lane LB/LBU on `0x80FF7F01`:
  - LB lane 3 → `0xFFFFFF80`; LBU lane 3 → `0x00000080`.
  - LB lane 1 → `0x0000007F`; LH lane 2 → `0xFFFF80FF`.
- SB `store_data=0x000000AB` at `ea=0x203` → `mem_wstrb=4'b1000`, `mem_wdata=0xABABABAB`, `mem_we=1`. SH at `ea=0x202` → `mem_wstrb=4'b1100`.
- LW at `ea=0x102`, SH at `ea=0x1`, store funct3=100 → `misaligned`, `misaligned`, `illegal`; `mem_req` stays 0 throughout.
- `mem_ready` delayed 5 cycles with a second `start` during the wait → outputs stable, second `start` ignored, `done` at T0+7.
- `base=0xFFFFFFFC`, `offset=8` → `mem_addr=0x00000004` (wrap). Assert `rst` during REQ → `mem_req=0` next cycle, no `done`, `busy=0`.
